// File: rtl/mips_exec_arith.sv
// mips_exec_arith: PC+4 and branch-target adders, 32-bit MIPS ALU and a debug capture register.
// Combinational results feed the same-cycle datapath muxes; result_q/zero_q/overflow_q observe the last captured ALU output.
module mips_exec_arith #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       alu_select,
    input  logic             capture_en,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             overflow,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q,
    output logic             overflow_q
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [WIDTH-1:0] sum, diff;
    logic             slt, ov_add, ov_sub;

    assign pc_plus4      = pc_in + WIDTH'(4);
    assign branch_target = pc_plus4 + branch_offset;

    assign sum  = operand1 + operand2;
    assign diff = operand1 - operand2;
    // SLT uses a true signed compare so it stays correct when A-B overflows
    assign slt    = $signed(operand1) < $signed(operand2);
    assign ov_add = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (sum[WIDTH-1] != operand1[WIDTH-1]);
    assign ov_sub = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (diff[WIDTH-1] != operand1[WIDTH-1]);

    always_comb begin
        alu_result = alu_select == OP_AND ? operand1 & operand2 :
                     alu_select == OP_OR  ? operand1 | operand2 :
                     alu_select == OP_ADD ? sum :
                     alu_select == OP_SUB ? diff :
                     alu_select == OP_SLT ? {{(WIDTH-1){1'b0}}, slt} :
                     alu_select == OP_NOR ? ~(operand1 | operand2) :
                     '0;
        overflow   = alu_select == OP_ADD ? ov_add :
                     alu_select == OP_SUB ? ov_sub : 1'b0;
    end

    assign zero_flag = alu_result == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (capture_en) begin
            result_q   <= alu_result;
            zero_q     <= zero_flag;
            overflow_q <= overflow;
        end
    end
endmodule

// File: tb/tb_mips_exec_arith.sv
// tb_mips_exec_arith: directed vectors pushed to a scoreboard queue; a monitor pops and compares at each falling edge.
module tb_mips_exec_arith;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_in = '0, branch_offset = '0, operand1 = '0, operand2 = '0;
    logic [3:0]  alu_select = '0;
    logic        capture_en = 1'b0;
    logic [31:0] pc_plus4, branch_target, alu_result, result_q;
    logic        zero_flag, overflow, zero_q, overflow_q;
    logic        vld = 1'b0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        string       name;
        logic [31:0] pc4, bt, res;
        logic        zf, ov;
        logic [31:0] rq;
        logic        zq, oq;
    } exp_t;

    exp_t sb[$];

    mips_exec_arith #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .branch_offset(branch_offset),
        .operand1(operand1), .operand2(operand2), .alu_select(alu_select),
        .capture_en(capture_en), .pc_plus4(pc_plus4), .branch_target(branch_target),
        .alu_result(alu_result), .zero_flag(zero_flag), .overflow(overflow),
        .result_q(result_q), .zero_q(zero_q), .overflow_q(overflow_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
        end
    endtask

    task automatic issue(input logic rn, input logic cap, input logic [31:0] pc, input logic [31:0] off,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel, input exp_t e);
        @(posedge clk);
        #1;
        rst_n = rn; capture_en = cap; pc_in = pc; branch_offset = off;
        operand1 = a; operand2 = b; alu_select = sel;
        sb.push_back(e);
        vld = 1'b1;
    endtask

    // Monitor: outputs are valid at every falling edge while vld is high
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (vld) begin
                if (sb.size() == 0) begin
                    chk("monitor", "queue_nonempty", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk(e.name, "pc_plus4", pc_plus4, e.pc4);
                    chk(e.name, "branch_target", branch_target, e.bt);
                    chk(e.name, "alu_result", alu_result, e.res);
                    chk(e.name, "zero_flag", {31'd0, zero_flag}, {31'd0, e.zf});
                    chk(e.name, "overflow", {31'd0, overflow}, {31'd0, e.ov});
                    chk(e.name, "result_q", result_q, e.rq);
                    chk(e.name, "zero_q", {31'd0, zero_q}, {31'd0, e.zq});
                    chk(e.name, "overflow_q", {31'd0, overflow_q}, {31'd0, e.oq});
                end
            end
        end
    end

    initial begin
        // reset held with capture_en=1: comb outputs live, capture stays 0
        issue(0, 1, 32'h10, 32'h8, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000,
              '{"and_rst", 32'h14, 32'h1C, 32'h00F000F0, 0, 0, 32'h0, 0, 0});
        issue(1, 0, 32'hFFFFFFFC, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0001,
              '{"or_pcwrap", 32'h0, 32'h0, 32'hFFF0FFF0, 0, 0, 32'h0, 0, 0});
        issue(1, 0, 32'h20, 32'hFFFFFFF0, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b1100,
              '{"nor_backbr", 32'h24, 32'h14, 32'h000F000F, 0, 0, 32'h0, 0, 0});
        issue(1, 1, 32'h100, 32'h4, 32'h7FFFFFFF, 32'h1, 4'b0010,
              '{"add_ovf", 32'h104, 32'h108, 32'h80000000, 0, 1, 32'h0, 0, 0});
        issue(1, 0, 32'h100, 32'h4, 32'h5, 32'h5, 4'b0110,
              '{"sub_zero", 32'h104, 32'h108, 32'h0, 1, 0, 32'h80000000, 0, 1});
        issue(1, 1, 32'h100, 32'h4, 32'h80000000, 32'h1, 4'b0110,
              '{"sub_ovf", 32'h104, 32'h108, 32'h7FFFFFFF, 0, 1, 32'h80000000, 0, 1});
        issue(1, 1, 32'h100, 32'h4, 32'hFFFFFFFF, 32'h1, 4'b0111,
              '{"slt_neg", 32'h104, 32'h108, 32'h1, 0, 0, 32'h7FFFFFFF, 0, 1});
        issue(1, 1, 32'h100, 32'h4, 32'h1, 32'hFFFFFFFF, 4'b0111,
              '{"slt_pos", 32'h104, 32'h108, 32'h0, 1, 0, 32'h1, 0, 0});
        issue(1, 0, 32'h100, 32'h4, 32'h80000000, 32'h7FFFFFFF, 4'b0111,
              '{"slt_ovf", 32'h104, 32'h108, 32'h1, 0, 0, 32'h0, 1, 0});
        issue(1, 1, 32'h100, 32'h4, 32'hDEADBEEF, 32'h12345678, 4'b1111,
              '{"undef", 32'h104, 32'h108, 32'h0, 1, 0, 32'h0, 1, 0});
        issue(1, 1, 32'h100, 32'h4, 32'h3, 32'h4, 4'b0010,
              '{"add_cap", 32'h104, 32'h108, 32'h7, 0, 0, 32'h0, 1, 0});
        issue(1, 0, 32'h100, 32'h4, 32'h0000FFFF, 32'h0, 4'b0000,
              '{"hold1", 32'h104, 32'h108, 32'h0, 1, 0, 32'h7, 0, 0});
        issue(1, 0, 32'h100, 32'h4, 32'h1, 32'h2, 4'b0001,
              '{"hold2", 32'h104, 32'h108, 32'h3, 0, 0, 32'h7, 0, 0});
        // reset asserted mid-cycle: capture clears before any clock edge
        issue(0, 1, 32'h100, 32'h4, 32'h1, 32'h1, 4'b0010,
              '{"rst_mid", 32'h104, 32'h108, 32'h2, 0, 0, 32'h0, 0, 0});
        @(posedge clk);
        #1 vld = 1'b0;
        @(negedge clk);
        chk("end", "queue_left", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_exec_arith.md
# mips_exec_arith

Arithmetic core of the single-cycle MIPS datapath: the PC+4 incrementer, the branch-target adder and the 32-bit ALU in one block. All three produce combinational results used the same cycle by the PC-select muxes, register-file write-back mux and data memory. A clocked capture stage also holds the last ALU result and flags for debug and observation.

## Interface
Parameters:
- WIDTH, 32, datapath width; all data ports use it (only 32 is supported).

Ports:
- clk  in  1  system clock; capture register updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low; clears the capture register.
- pc_in  in  WIDTH  current PC value.
- branch_offset  in  WIDTH  sign-extended immediate, already shifted left by 2.
- operand1  in  WIDTH  ALU operand A (register rs).
- operand2  in  WIDTH  ALU operand B (rt or the sign-extended immediate).
- alu_select  in  4  ALU operation code from the ALU control unit.
- capture_en  in  1  load the capture register this cycle.
- pc_plus4  out  WIDTH  pc_in + 4, combinational.
- branch_target  out  WIDTH  pc_plus4 + branch_offset, combinational.
- alu_result  out  WIDTH  ALU result, combinational.
- zero_flag  out  1  1 when alu_result == 0, combinational.
- overflow  out  1  signed overflow of ADD/SUB, combinational; 0 for all other operations.
- result_q  out  WIDTH  registered alu_result.
- zero_q  out  1  registered zero_flag.
- overflow_q  out  1  registered overflow.

## Operation
- pc_plus4 = pc_in + 4, modulo 2^32. It has no carry out.
- branch_target = pc_plus4 + branch_offset, modulo 2^32. branch_offset is two's complement, so backward branches wrap correctly.
- ALU operations, selected by alu_select:
  - 0000 AND: bitwise A & B.
  - 0001 OR: bitwise A | B.
  - 0010 ADD: A + B.
  - 0110 SUB: A − B.
  - 0111 SLT: result is 1 if A < B as signed values, otherwise 0.
  - 1100 NOR: ~(A | B).
  - Any other code: result is 0, so zero_flag = 1 and overflow = 0.
- ADD and SUB wrap modulo 2^32 and never trap.
- overflow for ADD: operands have the same sign and the result sign differs.
- overflow for SUB: operands have different signs and the result sign differs from A.
- SLT is computed by a true signed comparison, so it is correct even when A − B overflows.
- zero_flag is derived from the final alu_result for every operation. The enclosing datapath ANDs it with Branch to select branch_target.
- The block has no internal state apart from the capture register. Combinational outputs never depend on clk or rst_n.

## Timing
- pc_plus4, branch_target, alu_result, zero_flag and overflow are purely combinational, with zero-cycle latency.
- When rst_n is 0: result_q, zero_q and overflow_q go to 0 immediately, asynchronously, and stay 0 while rst_n is low. Deassertion is synchronized by the enclosing design.
- On a rising clk edge with rst_n = 1 and capture_en = 1, result_q, zero_q and overflow_q take the current combinational alu_result, zero_flag and overflow. They are visible one cycle after the inputs.
- When capture_en = 0, all capture outputs hold their value.
- If rst_n asserts in the same cycle as capture_en = 1, reset wins and the outputs read 0.
- The combinational outputs keep working during reset.

## Test plan
- PC adders:
  - pc_in = 0x00000010, branch_offset = 0x00000008 -> pc_plus4 = 0x00000014, branch_target = 0x0000001C.
  - pc_in = 0xFFFFFFFC -> pc_plus4 = 0x00000000 (wrap-around).
  - branch_offset = 0xFFFFFFF0 with pc_in = 0x20 -> branch_target = 0x00000014.
- Logic ops with A = 0xF0F0F0F0, B = 0x0FF00FF0:
  - AND -> 0x00F000F0.
  - OR -> 0xFFF0FFF0.
  - NOR -> 0x000F000F.
  - zero_flag = 0 in all three cases.
- Arithmetic:
  - ADD 0x7FFFFFFF + 1 -> 0x80000000 with overflow = 1.
  - SUB 5 − 5 -> 0 with zero_flag = 1 and overflow = 0.
  - SUB 0x80000000 − 1 -> 0x7FFFFFFF with overflow = 1.
- SLT:
  - A = 0xFFFFFFFF, B = 1 -> 1.
  - A = 1, B = 0xFFFFFFFF -> 0 with zero_flag = 1.
  - A = 0x80000000, B = 0x7FFFFFFF -> 1.
  - Undefined code 1111 -> result 0 with zero_flag = 1.
- Capture register:
  - Assert rst_n = 0 mid-cycle -> result_q = 0, zero_q = 0 and overflow_q = 0 immediately.
  - Release reset, ADD 3 + 4 with capture_en = 1 -> result_q = 7 after the next edge.
  - capture_en = 0 with new inputs -> result_q stays 7.
